// File: rtl/sl_seq_ctrl_pkg.sv
// Shared types and helpers for the SL command sequencer.
package sl_seq_ctrl_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned NUM_SL = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        OpNop     = 2'd0,
        OpPreload = 2'd1,
        OpWrite   = 2'd2,
        OpRead    = 2'd3
    } sl_op_e;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StDacSet   = 3'd1,
        StSettle   = 3'd2,
        StLoad     = 3'd3,
        StRdSettle = 3'd4,
        StConv     = 3'd5,
        StResp     = 3'd6
    } sl_state_e;

    // Address layout: [4:3] selects an 8-SL region, [2:0] a channel within it.
    function automatic logic [1:0] sl_region(input logic [ADDR_W-1:0] a);
        return a[4:3];
    endfunction

    function automatic logic [2:0] sl_channel(input logic [ADDR_W-1:0] a);
        return a[2:0];
    endfunction

endpackage

// File: rtl/sl_seq_ctrl_if.sv
// Command and read-response handshake bundle between host and sequencer.
interface sl_seq_ctrl_if
    import sl_seq_ctrl_pkg::*;
#(
    parameter int unsigned DAC_W = 10,
    parameter int unsigned ADC_W = 12
) ();

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [NUM_CH*DAC_W-1:0]   cmd_data;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [NUM_CH*ADC_W-1:0]   rsp_data;
    logic [ADDR_W-1:0]         rsp_addr;
    logic                      rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

endinterface

// File: rtl/sl_cyc_timer.sv
// Loadable down-counter that stops at zero and flags it.
module sl_cyc_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sl_seq_ctrl.sv
// SL bank command sequencer: DAC set/settle/load for PRELOAD and WRITE, settle/convert/respond for READ.
module sl_seq_ctrl
    import sl_seq_ctrl_pkg::*;
#(
    parameter int unsigned DAC_W      = 10,
    parameter int unsigned ADC_W      = 12,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CONV_TMO   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    sl_seq_ctrl_if.slave            bus,
    output logic [NUM_CH*DAC_W-1:0] dac_code,
    output logic                    dac_update,
    output logic                    sl_pre_op_en,
    output logic                    sl_addr_en,
    output logic [ADDR_W-1:0]       addr,
    output logic                    read_mode,
    output logic                    adc_start,
    input  logic                    adc_done,
    input  logic [NUM_CH*ADC_W-1:0] adc_data,
    output logic                    busy
);

    localparam int unsigned TMR_MAX = (SETTLE_CYC > CONV_TMO) ? SETTLE_CYC : CONV_TMO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] CONV_LD   = TMR_W'(CONV_TMO - 1);

    sl_state_e               state_q, state_d;
    sl_op_e                  op_q;
    sl_op_e                  cmd_op;
    logic                    conv_first_q;
    logic [NUM_CH*DAC_W-1:0] dac_code_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [NUM_CH*ADC_W-1:0] rsp_data_q;
    logic                    rsp_err_q;

    logic                    accept;
    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_val;
    logic                    tmr_zero;
    logic                    cap_done;
    logic                    cap_tmo;

    assign cmd_op = sl_op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && (state_q == StIdle);

    // One timer serves both settle phases and the conversion timeout.
    sl_cyc_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        cap_done = 1'b0;
        cap_tmo  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cmd_op)
                        OpPreload, OpWrite: state_d = StDacSet;
                        OpRead: begin
                            state_d  = StRdSettle;
                            tmr_load = 1'b1;
                        end
                        OpNop: state_d = StIdle;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StDacSet: begin
                state_d  = StSettle;
                tmr_load = 1'b1;
            end
            StSettle: begin
                if (tmr_zero) state_d = StLoad;
            end
            StLoad: state_d = StIdle;
            StRdSettle: begin
                if (tmr_zero) begin
                    state_d  = StConv;
                    tmr_load = 1'b1;
                    tmr_val  = CONV_LD;
                end
            end
            StConv: begin
                // A done on the final timeout cycle still wins over the error.
                if (adc_done) begin
                    cap_done = 1'b1;
                    state_d  = StResp;
                end else if (tmr_zero) begin
                    cap_tmo = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OpNop;
            conv_first_q <= 1'b0;
            dac_code_q   <= '0;
            addr_q       <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_first_q <= (state_q == StRdSettle) && (state_d == StConv);
            if (accept) begin
                addr_q <= bus.cmd_addr;
                op_q   <= cmd_op;
                if (cmd_op == OpPreload || cmd_op == OpWrite) begin
                    dac_code_q <= bus.cmd_data;
                end
            end
            if (cap_done) begin
                rsp_data_q <= adc_data;
                rsp_err_q  <= 1'b0;
            end else if (cap_tmo) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign dac_code      = dac_code_q;
    assign addr          = addr_q;
    assign dac_update    = (state_q == StDacSet);
    assign sl_pre_op_en  = (state_q == StLoad) && (op_q == OpPreload);
    assign sl_addr_en    = (state_q == StLoad) && (op_q == OpWrite);
    assign read_mode     = (state_q == StRdSettle) || (state_q == StConv) || (state_q == StResp);
    assign adc_start     = (state_q == StConv) && conv_first_q;
    assign busy          = (state_q != StIdle);

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = addr_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sl_seq_ctrl.sv
// Randomized and directed bench for sl_seq_ctrl against a cycle-count reference model.
module tb_sl_seq_ctrl;

    localparam int unsigned DAC_W      = 10;
    localparam int unsigned ADC_W      = 12;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned CONV_TMO   = 255;
    localparam int unsigned DW         = 8 * DAC_W;
    localparam int unsigned AW         = 8 * ADC_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sl_seq_ctrl_if #(.DAC_W(DAC_W), .ADC_W(ADC_W)) bus ();

    logic [DW-1:0] dac_code;
    logic          dac_update, sl_pre_op_en, sl_addr_en, read_mode, adc_start, adc_done, busy;
    logic [4:0]    addr;
    logic [AW-1:0] adc_data;

    sl_seq_ctrl #(
        .DAC_W      (DAC_W),
        .ADC_W      (ADC_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CONV_TMO   (CONV_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dac_code     (dac_code),
        .dac_update   (dac_update),
        .sl_pre_op_en (sl_pre_op_en),
        .sl_addr_en   (sl_addr_en),
        .addr         (addr),
        .read_mode    (read_mode),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since a command was accepted (k=1 is the first busy cycle).
    bit            m_valid = 0;
    bit            m_active, m_resp, m_err;
    int            m_k;
    logic [1:0]    m_op;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_dac;
    logic [AW-1:0] m_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_active = 0; m_resp = 0; m_err = 0; m_k = 0;
            m_op = 0; m_addr = 0; m_dac = '0; m_rdata = '0;
        end else if (m_valid) begin
            if (!m_active) begin
                if (bus.cmd_valid) begin
                    m_addr = bus.cmd_addr;
                    if (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2) m_dac = bus.cmd_data;
                    if (bus.cmd_op != 2'd0) begin
                        m_active = 1; m_op = bus.cmd_op; m_k = 1; m_resp = 0;
                    end
                end
            end else if (m_op != 2'd3) begin
                if (m_k == SETTLE_CYC + 2) m_active = 0;
                else m_k++;
            end else if (m_resp) begin
                if (bus.rsp_ready) m_active = 0;
            end else if (m_k >= SETTLE_CYC + 1 && adc_done) begin
                m_rdata = adc_data; m_err = 0; m_resp = 1;
            end else if (m_k == SETTLE_CYC + CONV_TMO) begin
                m_rdata = '0; m_err = 1; m_resp = 1;
            end else begin
                m_k++;
            end
        end
    end

    bit e_rd, e_wr;
    always @(negedge clk) begin
        if (m_valid) begin
            e_rd = m_active && (m_op == 2'd3);
            e_wr = m_active && (m_op != 2'd3);
            chk("cmd_ready",    bus.cmd_ready, !m_active);
            chk("busy",         busy,          m_active);
            chk("dac_update",   dac_update,    e_wr && m_k == 1);
            chk("sl_pre_op_en", sl_pre_op_en,  e_wr && m_op == 2'd1 && m_k == SETTLE_CYC + 2);
            chk("sl_addr_en",   sl_addr_en,    e_wr && m_op == 2'd2 && m_k == SETTLE_CYC + 2);
            chk("read_mode",    read_mode,     e_rd);
            chk("adc_start",    adc_start,     e_rd && !m_resp && m_k == SETTLE_CYC + 1);
            chk("rsp_valid",    bus.rsp_valid, e_rd && m_resp);
            chk("dac_code",     dac_code,      m_dac);
            chk("addr",         addr,          m_addr);
            chk("rsp_addr",     bus.rsp_addr,  m_addr);
            chk("rsp_data",     bus.rsp_data,  m_rdata);
            chk("rsp_err",      bus.rsp_err,   m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [DW-1:0] d);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
    endtask

    task automatic wait_start(input string name, output int t);
        t = 0;
        while (t < 20 && !adc_start) begin step(); t++; end
        chk(name, adc_start, 1'b1);
    endtask

    logic [DW-1:0] codes_inc, codes_ones, rnd_codes;
    logic [AW-1:0] rd100, rnd_adc;
    int t, n, stable;

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_data = '0; bus.rsp_ready = 0;
        adc_done = 0; adc_data = '0;
        for (int i = 0; i < 8; i++) begin
            codes_inc[i*DAC_W +: DAC_W] = DAC_W'(i);
            rd100[i*ADC_W +: ADC_W]     = ADC_W'(i * 100);
        end
        codes_ones = {DW{1'b1}};
        step(); step();
        chk("reset_dac_code", dac_code, '0);
        chk("reset_ready", bus.cmd_ready, 1'b1);
        rst = 1'b0;

        // WRITE addr 13, codes 0..7.
        send(2'd2, 5'd13, codes_inc);
        step();
        bus.cmd_valid = 0;
        chk("wr_dac_update", dac_update, 1'b1);
        chk("wr_dac_code", dac_code, codes_inc);
        t = 0; n = 0;
        while (t < 20 && !sl_addr_en) begin step(); t++; n += int'(sl_pre_op_en); end
        chk("wr_strobe_delay", t, 5);
        chk("wr_addr", addr, 5'd13);
        chk("wr_no_preop", n + int'(sl_pre_op_en), 0);
        step();
        chk("wr_strobe_width", sl_addr_en, 1'b0);
        chk("wr_ready_after", bus.cmd_ready, 1'b1);

        // PRELOAD all-ones, with a WRITE queued behind it on a held cmd_valid.
        send(2'd1, 5'd3, codes_ones);
        step();
        chk("pre_dac_update", dac_update, 1'b1);
        send(2'd2, 5'd9, codes_inc);
        t = 0;
        while (t < 20 && !sl_pre_op_en) begin step(); t++; end
        chk("pre_strobe_delay", t, 5);
        chk("pre_dac_code", dac_code, codes_ones);
        n = int'(sl_pre_op_en);
        step();
        n += int'(sl_pre_op_en);
        chk("pre_ready_t6", bus.cmd_ready, 1'b1);
        step();
        n += int'(sl_pre_op_en);
        bus.cmd_valid = 0;
        chk("pre_once", n, 1);
        chk("pre_next_accepted", dac_update, 1'b1);
        t = 0;
        while (t < 50 && !bus.cmd_ready) begin step(); t++; end
        chk("pre_back_idle", bus.cmd_ready, 1'b1);

        // READ addr 17, done 3 cycles after start, response back-pressured 10 cycles.
        send(2'd3, 5'd17, '0);
        step();
        bus.cmd_valid = 0;
        chk("rd_mode_on", read_mode, 1'b1);
        wait_start("rd_start_seen", t);
        chk("rd_start_delay", t, SETTLE_CYC);
        step(); step(); step();
        adc_done = 1; adc_data = rd100;
        step();
        adc_done = 0; adc_data = {AW{1'b1}};
        chk("rd_valid", bus.rsp_valid, 1'b1);
        chk("rd_data", bus.rsp_data, rd100);
        chk("rd_addr", bus.rsp_addr, 5'd17);
        chk("rd_err", bus.rsp_err, 1'b0);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.rsp_valid || bus.rsp_data !== rd100 || !read_mode || bus.cmd_ready) stable = 0;
        end
        chk("rd_hold_stable", stable, 1);
        bus.rsp_ready = 1;
        step();
        bus.rsp_ready = 0;
        chk("rd_mode_off", read_mode, 1'b0);
        chk("rd_ready_after", bus.cmd_ready, 1'b1);

        // READ with no adc_done: timeout response.
        send(2'd3, 5'd5, '0);
        step();
        bus.cmd_valid = 0;
        wait_start("tmo_start_seen", t);
        t = 0;
        while (t < 400 && !bus.rsp_valid) begin step(); t++; end
        chk("tmo_delay", t, CONV_TMO);
        chk("tmo_err", bus.rsp_err, 1'b1);
        chk("tmo_data", bus.rsp_data, '0);
        bus.rsp_ready = 1;
        step();
        bus.rsp_ready = 0;

        // Reset during SETTLE.
        send(2'd2, 5'd7, codes_ones);
        step();
        bus.cmd_valid = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_settle_dac", dac_code, '0);
        chk("rst_settle_addr", addr, 5'd0);
        chk("rst_settle_ready", bus.cmd_ready, 1'b1);
        n = 0;
        for (int i = 0; i < 10; i++) begin step(); n += int'(sl_addr_en) + int'(sl_pre_op_en); end
        chk("rst_settle_no_strobe", n, 0);

        // Reset during CONV.
        send(2'd3, 5'd9, '0);
        step();
        bus.cmd_valid = 0;
        wait_start("rst_conv_start_seen", t);
        step(); step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_conv_valid", bus.rsp_valid, 1'b0);
        chk("rst_conv_mode", read_mode, 1'b0);
        chk("rst_conv_ready", bus.cmd_ready, 1'b1);
        adc_done = 1; adc_data = rd100;
        n = 0;
        for (int i = 0; i < 10; i++) begin step(); n += int'(bus.rsp_valid); end
        adc_done = 0;
        chk("rst_conv_no_rsp", n, 0);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++) begin
                rnd_codes[i*DAC_W +: DAC_W] = DAC_W'($urandom);
                rnd_adc[i*ADC_W +: ADC_W]   = ADC_W'($urandom);
            end
            bus.cmd_valid = ($urandom_range(1) == 1);
            bus.cmd_op    = 2'($urandom);
            bus.cmd_addr  = 5'($urandom);
            bus.cmd_data  = rnd_codes;
            bus.rsp_ready = ($urandom_range(2) != 0);
            adc_done      = ($urandom_range(5) == 0);
            adc_data      = rnd_adc;
            rst           = ($urandom_range(299) == 0);
            step();
        end
        rst = 0; bus.cmd_valid = 0; adc_done = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
